// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the CPU run/step controller: FSM states, mode switch values and key indices.
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RST    = 2'd0,
        ST_IDLE   = 2'd1,
        ST_RUN    = 2'd2,
        ST_HALTED = 2'd3
    } run_state_e;

    typedef enum logic [1:0] {
        MODE_HALT = 2'd0,
        MODE_STEP = 2'd1,
        MODE_SLOW = 2'd2,
        MODE_FULL = 2'd3
    } mode_e;

    localparam int NUM_KEYS   = 3;
    localparam int KEY_STEP   = 0;
    localparam int KEY_SRST   = 1;
    localparam int KEY_RESUME = 2;

endpackage

// File: rtl/key_debounce.sv
// One push-button channel: 2-FF synchroniser, stable-level debouncer and a one-cycle press pulse.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic key_n_i,
    output logic press_o
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             sample;
    logic             level_q;
    logic             armed_q;
    logic             press_q;
    logic [CNT_W-1:0] cnt_q;

    // Synchroniser keeps sampling through reset so a key held across reset is seen at once.
    always_ff @(posedge clk_i) begin
        sync_q <= {sync_q[0], ~key_n_i};
    end

    assign sample = sync_q[1];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            level_q <= 1'b0;
            armed_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            press_q <= 1'b0;
            if (!sample) begin
                armed_q <= 1'b1;
            end
            if (sample == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                level_q <= sample;
                cnt_q   <= '0;
                // Only a key seen released since reset may produce a press event.
                press_q <= sample & armed_q;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step controller for cpu_16bit: debounced keys, halt/step/slow/full run sequencing,
// stretched soft reset and a saturating executed-instruction counter.
module cpu_run_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int RUN_DIV         = 25000000,
    parameter int RST_HOLD        = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  key_n,
    input  logic [1:0]  mode_sw,
    input  logic        halt_req,
    output logic        cpu_en,
    output logic        cpu_rst,
    output logic [1:0]  run_state,
    output logic [15:0] instr_cnt
);
    localparam int DIV_W  = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(RUN_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [NUM_KEYS-1:0] press;
    logic [1:0]          mode_s1_q;
    logic [1:0]          mode_s2_q;
    mode_e               mode;
    run_state_e          state_q;
    logic [HOLD_W-1:0]   hold_q;
    logic [DIV_W-1:0]    div_q;
    logic                en_q;
    logic                rst_q;
    logic [15:0]         cnt_q;
    logic [15:0]         cnt_d;
    logic                halt_hit;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk_i  (clk),
            .reset_i(reset),
            .key_n_i(key_n[g]),
            .press_o(press[g])
        );
    end

    always_ff @(posedge clk) begin
        mode_s1_q <= mode_sw;
        mode_s2_q <= mode_s1_q;
    end

    assign mode     = mode_e'(mode_s2_q);
    assign cnt_d    = sat_inc16(cnt_q);
    assign halt_hit = en_q & halt_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RST;
            hold_q  <= '0;
            div_q   <= '0;
            en_q    <= 1'b0;
            rst_q   <= 1'b1;
            cnt_q   <= '0;
        end else begin
            en_q <= 1'b0;
            // Soft reset outranks every other request, including a pending halt.
            if (press[KEY_SRST]) begin
                state_q <= ST_RST;
                hold_q  <= '0;
                div_q   <= '0;
                rst_q   <= 1'b1;
            end else begin
                case (state_q)
                    ST_RST: begin
                        if (hold_q == HOLD_LAST) begin
                            state_q <= ST_IDLE;
                            rst_q   <= 1'b0;
                            cnt_q   <= '0;
                        end else begin
                            hold_q <= hold_q + HOLD_W'(1);
                        end
                    end
                    ST_IDLE: begin
                        if (halt_hit) begin
                            state_q <= ST_HALTED;
                        end else if (mode == MODE_SLOW || mode == MODE_FULL) begin
                            state_q <= ST_RUN;
                            div_q   <= '0;
                        end else if (mode == MODE_STEP && press[KEY_STEP]) begin
                            en_q  <= 1'b1;
                            cnt_q <= cnt_d;
                        end
                    end
                    ST_RUN: begin
                        if (halt_hit) begin
                            state_q <= ST_HALTED;
                            div_q   <= '0;
                        end else if (mode == MODE_FULL) begin
                            en_q  <= 1'b1;
                            cnt_q <= cnt_d;
                            div_q <= '0;
                        end else if (mode == MODE_SLOW) begin
                            if (div_q == DIV_LAST) begin
                                en_q  <= 1'b1;
                                cnt_q <= cnt_d;
                                div_q <= '0;
                            end else begin
                                div_q <= div_q + DIV_W'(1);
                            end
                        end else begin
                            state_q <= ST_IDLE;
                            div_q   <= '0;
                        end
                    end
                    ST_HALTED: begin
                        if (press[KEY_RESUME]) begin
                            state_q <= ST_IDLE;
                        end
                    end
                    default: state_q <= ST_RST;
                endcase
            end
        end
    end

    assign cpu_en    = en_q;
    assign cpu_rst   = rst_q;
    assign run_state = state_q;
    assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: directed scenarios plus random stimulus against an event-level model.
module tb_cpu_run_ctrl;
    localparam int DB   = 4;
    localparam int DIV  = 3;
    localparam int HOLD = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  key_n;
    logic [1:0]  mode_sw;
    logic        halt_req;
    logic        cpu_en;
    logic        cpu_rst;
    logic [1:0]  run_state;
    logic [15:0] instr_cnt;

    int vectors     = 0;
    int miscompares = 0;

    cpu_run_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .RUN_DIV        (DIV),
        .RST_HOLD       (HOLD)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .key_n    (key_n),
        .mode_sw  (mode_sw),
        .halt_req (halt_req),
        .cpu_en   (cpu_en),
        .cpu_rst  (cpu_rst),
        .run_state(run_state),
        .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: k counts clock edges; timestamps replace hardware counters.
    int         k = 0;
    logic [2:0] key_hist[$];
    logic [1:0] mode_hist[$];
    int         m_state     = 0;
    int         m_rst_since = 0;
    int         m_base      = 0;
    int         m_cnt       = 0;
    bit         m_en        = 1'b0;
    bit   [2:0] m_ev        = 3'b000;
    bit   [2:0] m_acc       = 3'b000;
    bit   [2:0] m_armed     = 3'b000;
    int         m_run[3]    = '{0, 0, 0};

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic [2:0] pressed;
        logic [1:0] msamp;
        bit         counting;
        bit         ten;
        bit   [2:0] nev;
        key_hist.push_back(~key_n);
        mode_hist.push_back(mode_sw);
        pressed = (key_hist.size() >= 3) ? key_hist[key_hist.size()-3] : 3'b000;
        msamp   = (mode_hist.size() >= 3) ? mode_hist[mode_hist.size()-3] : 2'b00;
        if (key_hist.size() > 4) void'(key_hist.pop_front());
        if (mode_hist.size() > 4) void'(mode_hist.pop_front());

        counting = 1'b0;
        ten      = 1'b0;
        if (reset) begin
            m_state = 0; m_rst_since = k; m_cnt = 0;
        end else if (m_ev[1]) begin
            m_state = 0; m_rst_since = k;
        end else begin
            case (m_state)
                0: if (k - m_rst_since == HOLD) begin m_state = 1; m_cnt = 0; end
                1: begin
                    if (m_en && halt_req) m_state = 3;
                    else if (msamp >= 2) m_state = 2;
                    else if (msamp == 1 && m_ev[0]) ten = 1'b1;
                end
                2: begin
                    if (m_en && halt_req) m_state = 3;
                    else if (msamp == 3) ten = 1'b1;
                    else if (msamp == 2) begin
                        counting = 1'b1;
                        ten = ((k - m_base) % DIV == 0);
                    end else m_state = 1;
                end
                3: if (m_ev[2]) m_state = 1;
                default: ;
            endcase
        end
        if (!counting) m_base = k;
        if (ten && m_cnt < 65535) m_cnt++;
        m_en = ten;

        nev = 3'b000;
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                m_acc[i] = 1'b0; m_run[i] = 0; m_armed[i] = 1'b0;
            end else begin
                if (pressed[i] == m_acc[i]) m_run[i] = 0;
                else begin
                    m_run[i]++;
                    if (m_run[i] == DB) begin
                        m_acc[i] = pressed[i];
                        m_run[i] = 0;
                        nev[i]   = pressed[i] & m_armed[i];
                    end
                end
                if (!pressed[i]) m_armed[i] = 1'b1;
            end
        end
        m_ev = nev;
        k++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("cpu_en",    16'(cpu_en),    16'(m_en));
        chk("cpu_rst",   16'(cpu_rst),   16'(m_state == 0));
        chk("run_state", 16'(run_state), 16'(m_state));
        chk("instr_cnt", instr_cnt,      16'(m_cnt));
    endtask

    initial begin
        int pulses;
        reset = 1'b1; key_n = 3'b111; mode_sw = 2'b00; halt_req = 1'b0;
        tick(); tick();

        // 1: reset state and reset-hold stretch
        chk("t1_rst_in_reset", 16'(cpu_rst), 16'd1);
        chk("t1_en_in_reset", 16'(cpu_en), 16'd0);
        chk("t1_cnt_in_reset", instr_cnt, 16'd0);
        reset = 1'b0;
        repeat (3) begin tick(); chk("t1_rst_hold", 16'(cpu_rst), 16'd1); end
        tick();
        chk("t1_rst_released", 16'(cpu_rst), 16'd0);
        chk("t1_idle", 16'(run_state), 16'd1);

        // 2: single step with a bouncing STEP key
        mode_sw = 2'b01;
        repeat (3) tick();
        key_n[0] = 1'b0; tick();
        key_n[0] = 1'b1; tick();
        key_n[0] = 1'b0;
        pulses = 0;
        repeat (10) begin tick(); pulses += int'(cpu_en); end
        key_n[0] = 1'b1;
        repeat (8) begin tick(); pulses += int'(cpu_en); end
        chk("t2_step_pulses", 16'(pulses), 16'd1);
        chk("t2_cnt", instr_cnt, 16'd1);

        // 3: slow run then full run
        mode_sw = 2'b10;
        pulses = 0;
        repeat (15) begin tick(); pulses += int'(cpu_en); end
        chk("t3_slow_pulses", 16'(pulses), 16'd4);
        mode_sw = 2'b11;
        repeat (2) tick();
        repeat (4) begin tick(); chk("t3_full_en", 16'(cpu_en), 16'd1); end

        // 4: halt on the 5th enable after a soft reset, STEP ignored, RESUME returns to IDLE
        mode_sw = 2'b00;
        repeat (4) tick();
        key_n[1] = 1'b0; repeat (7) tick();
        key_n[1] = 1'b1; repeat (8) tick();
        chk("t4_idle_after_srst", 16'(run_state), 16'd1);
        chk("t4_cnt_cleared", instr_cnt, 16'd0);
        mode_sw = 2'b11;
        pulses = 0;
        for (int i = 0; i < 40 && pulses < 5; i++) begin tick(); pulses += int'(cpu_en); end
        chk("t4_enables_seen", 16'(pulses), 16'd5);
        halt_req = 1'b1; tick(); halt_req = 1'b0;
        chk("t4_halted", 16'(run_state), 16'd3);
        chk("t4_halt_cnt", instr_cnt, 16'd5);
        chk("t4_halt_no_en", 16'(cpu_en), 16'd0);
        mode_sw = 2'b01;
        key_n[0] = 1'b0; repeat (8) tick();
        key_n[0] = 1'b1; repeat (8) tick();
        chk("t4_step_ignored_state", 16'(run_state), 16'd3);
        chk("t4_step_ignored_cnt", instr_cnt, 16'd5);
        mode_sw = 2'b00;
        key_n[2] = 1'b0; repeat (8) tick();
        chk("t4_resume", 16'(run_state), 16'd1);
        key_n[2] = 1'b1; repeat (8) tick();

        // 5: soft reset in RUN coinciding with halt_req
        mode_sw = 2'b11;
        repeat (5) tick();
        key_n[1] = 1'b0; repeat (6) tick();
        chk("t5_running", 16'(cpu_en), 16'd1);
        halt_req = 1'b1; tick(); halt_req = 1'b0;
        chk("t5_state_rst", 16'(run_state), 16'd0);
        chk("t5_en_low", 16'(cpu_en), 16'd0);
        chk("t5_cpu_rst", 16'(cpu_rst), 16'd1);
        repeat (4) tick();
        chk("t5_idle_after_hold", 16'(run_state), 16'd1);
        chk("t5_cnt_zero", instr_cnt, 16'd0);
        key_n[1] = 1'b1; repeat (8) tick();

        // Random stimulus against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) mode_sw = 2'($urandom_range(0, 3));
            for (int j = 0; j < 3; j++) begin
                if ($urandom_range(0, (j == 1) ? 30 : 8) == 0) key_n[j] = ~key_n[j];
            end
            halt_req = ($urandom_range(0, 5) == 0);
            reset    = ($urandom_range(0, 299) == 0);
            tick();
        end

        // 6: STEP held through reset gives no event, then counter saturation
        reset = 1'b1; key_n = 3'b110; mode_sw = 2'b01; halt_req = 1'b0;
        tick(); tick();
        reset = 1'b0;
        repeat (14) tick();
        chk("t6_held_key_no_event", instr_cnt, 16'd0);
        key_n = 3'b111; mode_sw = 2'b11;
        for (int i = 0; i < 70000 && m_cnt < 16'hFFFE; i++) tick();
        chk("t6_cnt_fffe", instr_cnt, 16'hFFFE);
        repeat (3) tick();
        chk("t6_cnt_saturated", instr_cnt, 16'hFFFF);
        chk("t6_still_enabled", 16'(cpu_en), 16'd1);
        tick();
        chk("t6_no_wrap", instr_cnt, 16'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
